// File: rtl/pll_top_pkg.sv
// rtl/pll_top_pkg.sv - shared constants, lock FSM states and divider enable helper for pll_top
package pll_top_pkg;

    localparam int NUM_OUT = 6;
    localparam int LED_BIT = 3;
    localparam int PRESC_W = 3;
    localparam int DIV_RATIO [NUM_OUT] = '{1, 1, 2, 2, 4, 8};

    typedef enum logic [1:0] {
        ST_PWRDN   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    // Divide-by-D fires when the low log2(D) prescaler bits are all ones.
    function automatic logic div_enable(input int div, input logic [PRESC_W-1:0] presc);
        logic [PRESC_W-1:0] mask;
        mask = PRESC_W'(div - 1);
        return (presc & mask) == mask;
    endfunction

endpackage

// File: rtl/pll_top_div_counter.sv
// rtl/pll_top_div_counter.sv - wrapping output counter with clear and enable, exposing one tap bit
module pll_top_div_counter #(
    parameter int CNT_W   = 24,
    parameter int TAP_BIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tap
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tap = count[TAP_BIT];

endmodule

// File: rtl/pll_top.sv
// rtl/pll_top.sv - PLL emulation: lock FSM, prescaler and six divided LED counters (option: PLL_TOP_PWRDWN_SYNC_EN)
module pll_top
    import pll_top_pkg::*;
#(
    parameter int LOCK_CYCLES = 40,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwrdwn,
    output logic [6:0] led
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    logic pd;

`ifdef PLL_TOP_PWRDWN_SYNC_EN
    // Resets to "powered down" so nothing runs until the switch is seen low twice.
    logic [1:0] pd_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_sync <= 2'b11;
        end else begin
            pd_sync <= {pd_sync[0], pwrdwn};
        end
    end

    assign pd = pd_sync[1];
`else
    assign pd = pwrdwn;
`endif

    lock_state_e      state, state_nxt;
    logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
    logic             locked;
    logic [PRESC_W-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PWRDN;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Counting starts on the first edge with power-down low, even from ST_PWRDN.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (pd) begin
            state_nxt    = ST_PWRDN;
            lock_cnt_nxt = '0;
        end else begin
            case (state)
                ST_PWRDN, ST_ACQUIRE: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_nxt = ST_LOCKED;
                    end else begin
                        state_nxt    = ST_ACQUIRE;
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (pd || !locked) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        logic en;
        assign en = locked && !pd && div_enable(DIV_RATIO[i], presc);

        pll_top_div_counter #(
            .CNT_W   (CNT_W),
            .TAP_BIT (LED_BIT)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (pd),
            .en    (en),
            .tap   (led[i])
        );
    end

    assign led[6] = locked;

endmodule

// File: tb/tb_pll_top.sv
// tb/tb_pll_top.sv - randomized self-checking bench for pll_top against an arithmetic lock/divide model
module tb_pll_top;

    localparam int LC = 40;
`ifdef PLL_TOP_PWRDWN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int DIVS [6] = '{1, 1, 2, 2, 4, 8};

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       pwrdwn = 1'b0;
    logic [6:0] led;
    logic [6:0] led_w4;

    always #5 clk = ~clk;

    pll_top #(.LOCK_CYCLES(LC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwrdwn (pwrdwn),
        .led    (led)
    );

    pll_top #(.LOCK_CYCLES(LC), .CNT_W(4)) dut_w4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwrdwn (pwrdwn),
        .led    (led_w4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: run = consecutive edges that saw power-down low (after optional 2-edge delay).
    int   run;
    logic d1, d2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 0;
            d1  <= 1'b1;
            d2  <= 1'b1;
        end else begin
            d1 <= pwrdwn;
            d2 <= d1;
            if (SYNC_LAT != 0) run <= d2 ? 0 : run + 1;
            else               run <= pwrdwn ? 0 : run + 1;
        end
    end

    function automatic logic [6:0] model_led(input int r, input int w);
        logic [6:0] v;
        int k;
        int c;
        v = '0;
        if (r >= LC) begin
            v[6] = 1'b1;
            k = r - LC;
            for (int i = 0; i < 6; i++) begin
                c = (k / DIVS[i]) % (1 << w);
                v[i] = c[3];
            end
        end
        return v;
    endfunction

    int   cyc = 0;
    bit   measure = 0;
    int   last_rise [7];
    logic [6:0] prev_led = '0;
    logic       prev_w4  = 1'b0;

    task automatic start_measure();
        measure = 1;
        for (int i = 0; i < 7; i++) last_rise[i] = -1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("led", {25'd0, led}, {25'd0, model_led(run, 24)});
        check("led_w4", {25'd0, led_w4}, {25'd0, model_led(run, 4)});
        if (measure) begin
            for (int i = 0; i < 6; i++) begin
                if (led[i] && !prev_led[i]) begin
                    if (last_rise[i] >= 0)
                        check($sformatf("period%0d", i), cyc - last_rise[i], 16 * DIVS[i]);
                    last_rise[i] = cyc;
                end
            end
            if (led_w4[0] && !prev_w4) begin
                if (last_rise[6] >= 0) check("period_w4", cyc - last_rise[6], 16);
                last_rise[6] = cyc;
            end
        end
        prev_led = led;
        prev_w4  = led_w4[0];
    endtask

    task automatic measure_lock(input string tag);
        int n;
        n = 0;
        while (n < 300 && !led[6]) begin
            cycle();
            n++;
        end
        check(tag, n, LC + SYNC_LAT);
    endtask

    initial begin
        #1;
        rst_n  = 1'b0;
        pwrdwn = 1'b0;
        #2;
        check("rst_async", {25'd0, led}, 32'd0);
        repeat ($urandom_range(2, 5)) cycle();

        rst_n  = 1'b1;
        pwrdwn = 1'b1;
        repeat (100) cycle();
        check("pd_hold_led", {25'd0, led}, 32'd0);

        pwrdwn = 1'b0;
        start_measure();
        measure_lock("lock_latency");
        repeat (600) cycle();
        measure = 0;

        pwrdwn = 1'b1;
        repeat (3) cycle();
        check("pd_pulse_led", {25'd0, led}, 32'd0);
        pwrdwn = 1'b0;
        measure_lock("relock_latency");
        repeat (100) cycle();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) pwrdwn = ~pwrdwn;
            cycle();
        end

        pwrdwn = 1'b0;
        repeat (LC + SYNC_LAT + 80) cycle();
        check("pre_rst_locked", {31'd0, led[6]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_run", {25'd0, led}, 32'd0);
        check("rst_async_w4", {25'd0, led_w4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        measure_lock("lock_after_rst");
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
